// File: rtl/rr_arb4_pkt_pkg.sv
// Shared definitions for the rr_arb4_pkt round-robin packet arbiter.
// Contents:
//   NREQ    - number of requesters (4)
//   SEL_W   - width of a requester index (2)
//   state_t - FSM encoding, IDLE = 1'b0, BUSY = 1'b1
package rr_arb4_pkt_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb4_pkt_if.sv
// Bus bundle between four packet sources, the arbiter and one downstream sink.
// Signals:
//   in_valid[3:0], in_last[3:0]  per-requester beat valid / last-beat flag
//   in_data0..in_data3           per-requester beat data
//   in_ready[3:0]                per-requester ready, at most one bit high
//   out_valid, out_ready         downstream handshake
//   out_data, out_last           downstream beat, taken from the granted requester
//   sel                          current grant index
//   busy                         high while a packet grant is held
//   tmo_pulse                    one-cycle pulse on a forced (timeout) release
// Modports:
//   master - the environment (sources and sink) around the arbiter
//   slave  - the arbiter itself
interface rr_arb4_pkt_if #(
  parameter int width = 8
) ();
  import rr_arb4_pkt_pkg::*;

  logic [NREQ-1:0]  in_valid;
  logic [NREQ-1:0]  in_last;
  logic [width-1:0] in_data0;
  logic [width-1:0] in_data1;
  logic [width-1:0] in_data2;
  logic [width-1:0] in_data3;
  logic [NREQ-1:0]  in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;
  logic             out_last;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             tmo_pulse;

  modport master (
    output in_valid, in_last, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_last, sel, busy, tmo_pulse
  );

  modport slave (
    input  in_valid, in_last, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_last, sel, busy, tmo_pulse
  );

endinterface

// File: rtl/rr_arb4_pkt_mux4.sv
// Parameterised 4:1 multiplexer used as the shared datapath of the arbiter.
// Ports:
//   in0..in3  data inputs
//   s         select (2 bits)
//   out       selected input
module mux4 #(
  parameter int width = 8
) (
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  input  logic [width-1:0] in2,
  input  logic [width-1:0] in3,
  input  logic [1:0]       s,
  output logic [width-1:0] out
);

  always_comb begin
    case (s)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/rr_arb4_pkt.sv
// 4-requester round-robin packet arbiter. A grant is held for a whole packet
// (first beat through the accepted beat carrying in_last); priority then
// rotates to the port after the winner. An optional timeout forces a release
// when the granted source stalls too long.
// Parameters:
//   width    data bits per beat
//   timeout  BUSY cycles without an accepted beat before forced release (0 = off)
// Ports:
//   clk  clock, all state updates on posedge
//   rst  synchronous active-high reset
//   bus  rr_arb4_pkt_if.slave: request/ready per source, downstream stream,
//        sel / busy / tmo_pulse status
module rr_arb4_pkt
  import rr_arb4_pkt_pkg::*;
#(
  parameter int width   = 8,
  parameter int timeout = 0
) (
  input  logic           clk,
  input  logic           rst,
  rr_arb4_pkt_if.slave   bus
);

  // Counter only needs to reach timeout-1; keep at least one bit so the
  // design elaborates when the timeout is disabled.
  localparam int CNT_W = (timeout > 1) ? $clog2(timeout) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (timeout > 1) ? CNT_W'(timeout - 1) : '0;

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] pick;
  logic [CNT_W-1:0] idle_cnt;
  logic             tmo_q;
  logic             accept;
  logic             end_pkt;
  logic             tmo_hit;
  logic [width-1:0] mux_out;

  // Rotate the request vector so bit 0 is the current priority holder,
  // take the lowest set bit, then add ptr back to get the absolute index.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                                input logic [SEL_W-1:0] base);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SEL_W-1:0]  idx;
    dbl = {req, req};
    rot = NREQ'(dbl >> base);
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = SEL_W'(i);
    end
    return idx + base;
  endfunction

  assign pick = rr_pick(bus.in_valid, ptr);

  // No beat is accepted while rst is high, so an abandoned packet never
  // hands a beat downstream in the reset cycle.
  assign accept  = (state == ST_BUSY) && !rst && bus.in_valid[sel_q] && bus.out_ready;
  assign end_pkt = accept && bus.in_last[sel_q];
  // An accepted beat always beats the timeout in the same cycle.
  assign tmo_hit = (timeout > 0) && (state == ST_BUSY) && !accept && (idle_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one arbitration cycle in IDLE, then hold until the
  // packet ends or the timeout fires.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|bus.in_valid)        state_nxt = ST_BUSY;
      ST_BUSY: if (end_pkt || tmo_hit)   state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: only the granted source sees ready, and only when the
  // sink is ready.
  always_comb begin
    bus.busy      = (state == ST_BUSY);
    bus.out_valid = 1'b0;
    bus.in_ready  = '0;
    if (state == ST_BUSY && !rst) begin
      bus.out_valid = bus.in_valid[sel_q];
      if (bus.out_ready) bus.in_ready[sel_q] = 1'b1;
    end
  end

  // Grant index, rotation pointer, stall counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      ptr      <= '0;
      idle_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (state == ST_IDLE && |bus.in_valid) sel_q <= pick;
      if (end_pkt || tmo_hit)                ptr   <= sel_q + 1'b1;
      if (timeout == 0 || state == ST_IDLE || accept) idle_cnt <= '0;
      else                                            idle_cnt <= idle_cnt + 1'b1;
    end
  end

  mux4 #(.width(width)) u_mux (
    .in0 (bus.in_data0),
    .in1 (bus.in_data1),
    .in2 (bus.in_data2),
    .in3 (bus.in_data3),
    .s   (sel_q),
    .out (mux_out)
  );

  assign bus.out_data  = mux_out;
  assign bus.out_last  = bus.in_last[sel_q];
  assign bus.sel       = sel_q;
  assign bus.tmo_pulse = tmo_q;

endmodule
